// File: rtl/cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache with one word per line.
// Ports: clk/rst (async, active-low); CPU side req_valid/req_ready, op_type,
// address, i_val, resp_valid, o_val; flush; memory side mem_req_valid/ready,
// mem_we, mem_addr, mem_wdata, mem_resp_valid, mem_rdata; hit_cnt/miss_cnt.
module cache_dm #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              op_type,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] i_val,
    output logic              resp_valid,
    output logic [DATA_W-1:0] o_val,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   o_val_q, o_val_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    // Tag and data storage carry no reset; the valid bits gate their use.
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic                line_we;
    logic [IDX_W-1:0]    line_idx;
    logic [TAG_W-1:0]    line_tag;
    logic [DATA_W-1:0]   line_data;

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                req_hit;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                addr_unused;

    assign req_idx     = address[IDX_W+1:2];
    assign req_tag     = address[ADDR_W-1:IDX_W+2];
    assign req_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    // The outstanding request address doubles as the refill location.
    assign fill_idx    = mem_addr_q[IDX_W+1:2];
    assign fill_tag    = mem_addr_q[ADDR_W-1:IDX_W+2];
    assign addr_unused = &address[1:0];

    assign req_ready     = (state_q == IDLE) && !flush;
    assign resp_valid    = resp_valid_q;
    assign o_val         = o_val_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        resp_valid_d    = 1'b0;
        o_val_d         = o_val_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        line_we         = 1'b0;
        line_idx        = req_idx;
        line_tag        = req_tag;
        line_data       = i_val;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (req_valid) begin
                    if (!op_type && req_hit) begin
                        resp_valid_d = 1'b1;
                        o_val_d      = data_mem[req_idx];
                        hit_cnt_d    = hit_cnt_q + 32'd1;
                    end else begin
                        state_d         = MEM_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = op_type;
                        mem_addr_d      = {address[ADDR_W-1:2], 2'b00};
                        if (op_type) begin
                            mem_wdata_d = i_val;
                            line_we     = req_hit;
                        end else begin
                            miss_cnt_d  = miss_cnt_q + 32'd1;
                        end
                    end
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        o_val_d           = mem_rdata;
                        valid_d[fill_idx] = 1'b1;
                        line_we           = 1'b1;
                        line_idx          = fill_idx;
                        line_tag          = fill_tag;
                        line_data         = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            resp_valid_q    <= 1'b0;
            o_val_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            resp_valid_q    <= resp_valid_d;
            o_val_q         <= o_val_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_idx]  <= line_tag;
            data_mem[line_idx] <= line_data;
        end
    end

endmodule

// File: tb/tb_cache_dm.sv
// Self-checking bench for cache_dm: directed table, corner sequences and
// randomized traffic against an array-based cache/memory reference model.
module tb_cache_dm;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        op_type;
    logic [31:0] address;
    logic [31:0] i_val;
    logic        resp_valid;
    logic [31:0] o_val;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    cache_dm dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .op_type        (op_type),
        .address        (address),
        .i_val          (i_val),
        .resp_valid     (resp_valid),
        .o_val          (o_val),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // environment memory (responder side)
    logic [31:0] mem_env [logic [29:0]];
    int          ready_lat = 0;
    int          resp_lat  = 1;
    int          hs_count  = 0;
    int          stab_viol = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [31:0] last_addr = 0;
    logic        last_we = 0;
    logic [31:0] last_wdata = 0;

    // reference model state
    bit          rv   [16];
    logic [25:0] rt   [16];
    logic [31:0] rdat [16];
    logic [31:0] rmem [logic [29:0]];
    logic [31:0] mh;
    logic [31:0] mm;

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // memory responder: accepts after ready_lat stall cycles, answers after
    // resp_lat cycles, and checks the request stays stable while stalled
    initial begin
        bit          seen;
        bit          pend;
        bit          hs;
        int          wcnt;
        int          rcnt;
        logic [31:0] s_addr;
        logic [31:0] s_wd;
        logic        s_we;
        logic [31:0] rd;
        seen = 0; pend = 0; hs = 0; wcnt = 0; rcnt = 0;
        s_addr = 0; s_wd = 0; s_we = 0; rd = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (!rst) begin
                seen = 0; pend = 0; hs = 0;
                mem_req_ready = 1'b0;
                continue;
            end
            if (hs) begin
                hs = 0;
                mem_req_ready = 1'b0;
                pend = 1;
                rcnt = resp_lat;
                hs_count++;
                last_addr  = s_addr;
                last_we    = s_we;
                last_wdata = s_wd;
                if (s_we) begin
                    mem_env[s_addr[31:2]] = s_wd;
                end else if (mem_env.exists(s_addr[31:2])) begin
                    rd = mem_env[s_addr[31:2]];
                end else begin
                    rd = init_val(s_addr[31:2]);
                end
            end
            if (pend) begin
                if (rcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = rd;
                    pend = 0;
                end else begin
                    rcnt--;
                end
            end else if (stray_req != stray_done) begin
                stray_done++;
                mem_resp_valid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            if (mem_req_valid && !pend && !hs) begin
                if (!seen) begin
                    seen   = 1;
                    wcnt   = ready_lat;
                    s_addr = mem_addr;
                    s_we   = mem_we;
                    s_wd   = mem_wdata;
                end else if (mem_addr !== s_addr || mem_we !== s_we ||
                             mem_wdata !== s_wd) begin
                    stab_viol++;
                end
                if (wcnt == 0) begin
                    mem_req_ready = 1'b1;
                    hs = 1;
                    seen = 0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) rv[i] = 0;
        mh = 0;
        mm = 0;
    endfunction

    function automatic void model(input bit st, input logic [31:0] a,
                                  input logic [31:0] d, output bit hit,
                                  output logic [31:0] data);
        int          idx;
        logic [25:0] tg;
        logic [29:0] w;
        idx  = int'(a[5:2]);
        tg   = a[31:6];
        w    = a[31:2];
        hit  = rv[idx] && rt[idx] == tg;
        data = '0;
        if (!st) begin
            if (hit) begin
                data = rdat[idx];
                mh++;
            end else begin
                data = rmem.exists(w) ? rmem[w] : init_val(w);
                rv[idx] = 1;
                rt[idx] = tg;
                rdat[idx] = data;
                mm++;
            end
        end else begin
            if (hit) rdat[idx] = d;
            rmem[w] = d;
        end
    endfunction

    // starts and ends just after a falling edge
    task automatic do_req(input bit st, input logic [31:0] a,
                          input logic [31:0] d, output bit got,
                          output int lat, output logic [31:0] data,
                          output int nmem, output logic [31:0] ma,
                          output bit mwe, output logic [31:0] mwd,
                          output int nstab);
        int h0;
        int s0;
        int w;
        h0 = hs_count;
        s0 = stab_viol;
        req_valid = 1'b1;
        op_type   = st;
        address   = a;
        i_val     = d;
        #1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got  = resp_valid;
        data = o_val;
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        nmem  = hs_count - h0;
        ma    = last_addr;
        mwe   = last_we;
        mwd   = last_wdata;
        nstab = stab_viol - s0;
    endtask

    task automatic check_req(input bit st, input logic [31:0] a,
                             input logic [31:0] d, input bit ehit,
                             input logic [31:0] edata,
                             input logic [31:0] eh, input logic [31:0] em);
        bit          got;
        int          lat;
        logic [31:0] data;
        int          nmem;
        logic [31:0] ma;
        bit          mwe;
        logic [31:0] mwd;
        int          nstab;
        do_req(st, a, d, got, lat, data, nmem, ma, mwe, mwd, nstab);
        chk("resp_seen", 32'(got), 32'd1);
        chk("mem_stable", nstab, 0);
        if (ehit && !st) begin
            chk("hit_lat", lat, 1);
            chk("hit_no_mem", nmem, 0);
        end else begin
            chk("mem_req_cnt", nmem, 1);
            chk("mem_addr", ma, {a[31:2], 2'b00});
            chk("mem_we", 32'(mwe), 32'(st));
            if (st) chk("mem_wdata", mwd, d);
        end
        if (!st) chk("o_val", data, edata);
        chk("hit_cnt", hit_cnt, eh);
        chk("miss_cnt", miss_cnt, em);
    endtask

    task automatic model_req(input bit st, input logic [31:0] a,
                             input logic [31:0] d);
        bit          h;
        logic [31:0] v;
        model(st, a, d, h, v);
        check_req(st, a, d, h, v, mh, mm);
    endtask

    task automatic do_flush(input bit with_req, input logic [31:0] a);
        int h0;
        h0 = hs_count;
        flush = 1'b1;
        req_valid = with_req;
        op_type = 1'b0;
        address = a;
        #1;
        chk("flush_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_no_resp", 32'(resp_valid), 32'd0);
        chk("flush_no_mem", 32'(mem_req_valid), 32'd0);
        chk("flush_no_hs", hs_count - h0, 0);
        for (int i = 0; i < 16; i++) rv[i] = 0;
    endtask

    typedef struct {
        bit          st;
        logic [31:0] a;
        logic [31:0] d;
        bit          hit;
        logic [31:0] exp;
        logic [31:0] eh;
        logic [31:0] em;
    } vec_t;

    vec_t tbl [8];

    initial begin
        bit          h;
        logic [31:0] v1;
        logic [31:0] v2;
        int          h0;

        tbl[0] = '{0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 0, 1};
        tbl[1] = '{0, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1, 1};
        tbl[2] = '{1, 32'h100, 32'h12345678, 1, 32'h0,        1, 1};
        tbl[3] = '{0, 32'h100, 32'h0,        1, 32'h12345678, 2, 1};
        tbl[4] = '{0, 32'h140, 32'h0,        0, 32'hCAFEF00D, 2, 2};
        tbl[5] = '{0, 32'h100, 32'h0,        0, 32'h12345678, 2, 3};
        tbl[6] = '{0, 32'h140, 32'h0,        0, 32'hCAFEF00D, 2, 4};
        tbl[7] = '{0, 32'h140, 32'h0,        1, 32'hCAFEF00D, 3, 4};

        req_valid = 0; op_type = 0; address = 0; i_val = 0; flush = 0;
        mem_env[30'h40] = 32'hDEADBEEF;
        mem_env[30'h50] = 32'hCAFEF00D;
        rmem[30'h40] = 32'hDEADBEEF;
        rmem[30'h50] = 32'hCAFEF00D;
        model_reset();

        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_o_val", o_val, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        resp_lat  = 3;
        ready_lat = 0;
        for (int i = 0; i < 8; i++) begin
            model(tbl[i].st, tbl[i].a, tbl[i].d, h, v1);
            check_req(tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].hit,
                      tbl[i].exp, tbl[i].eh, tbl[i].em);
        end

        // back-to-back hits at one per cycle
        model_req(0, 32'h104, 32'h0);
        model(0, 32'h140, 32'h0, h, v1);
        model(0, 32'h104, 32'h0, h, v2);
        req_valid = 1'b1;
        op_type = 1'b0;
        address = 32'h140;
        @(posedge clk);
        @(negedge clk);
        address = 32'h107;
        chk("b2b_resp0", 32'(resp_valid), 32'd1);
        chk("b2b_data0", o_val, v1);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_resp1", 32'(resp_valid), 32'd1);
        chk("b2b_data1", o_val, v2);
        @(negedge clk);
        chk("b2b_end", 32'(resp_valid), 32'd0);
        chk("b2b_hit_cnt", hit_cnt, mh);

        // flush beats a same-cycle request; 0x140 then misses
        do_flush(1, 32'h140);
        model_req(0, 32'h140, 32'h0);
        chk("flush_miss_cnt", miss_cnt, 32'd6);

        // stalled memory handshake
        ready_lat = 5;
        model_req(0, 32'h200, 32'h0);
        ready_lat = 4;
        model_req(1, 32'h208, 32'hA5A5F00F);
        ready_lat = 0;

        // reset while waiting on memory
        resp_lat = 20;
        h0 = hs_count;
        req_valid = 1'b1;
        op_type = 1'b0;
        address = 32'h380;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int w = 0; w < 20 && hs_count == h0; w++) @(negedge clk);
        chk("rst_test_hs", hs_count - h0, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_hit_cnt", hit_cnt, 32'd0);
        chk("midrst_miss_cnt", miss_cnt, 32'd0);
        chk("midrst_o_val", o_val, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        stray_req++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stray_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("stray_sent", stray_done, stray_req);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        resp_lat = 1;
        model_req(0, 32'h380, 32'h0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                $urandom_range(0, 3);
            ready_lat = $urandom_range(0, 2);
            resp_lat  = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) begin
                do_flush($urandom_range(0, 1) == 1, a);
            end else begin
                model_req($urandom_range(0, 2) == 0, a, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_dm.md
CACHE_DM -- requirements
Module: cache_dm

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped one-word lines (power of 2, >=2).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DATA_W, default 32, data word width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  CPU request present.
REQ-007 req_ready  out  1  cache can accept a CPU request.
REQ-008 op_type  in  1  0 = load, 1 = store.
REQ-009 address  in  ADDR_W  CPU byte address (bits [1:0] ignored).
REQ-010 i_val  in  DATA_W  store data.
REQ-011 resp_valid  out  1  one-cycle pulse, request complete.
REQ-012 o_val  out  DATA_W  load data, valid with resp_valid.
REQ-013 flush  in  1  invalidate all lines.
REQ-014 mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
REQ-015 mem_we  out  1  memory request is a write.
REQ-016 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
REQ-017 mem_resp_valid / mem_rdata  in  1 / DATA_W  memory completion and read data.
REQ-018 hit_cnt / miss_cnt  out  32 / 32  load hit / load miss counters.

Function
REQ-019 Index = address[log2(LINES)+1:2]; tag = address[ADDR_W-1:log2(LINES)+2]; per line: valid bit, tag, data word.
REQ-020 FSM states IDLE, MEM_REQ, MEM_WAIT; req_ready = 1 only in IDLE with flush low.
REQ-021 Request accepted on a rising edge with req_valid & req_ready; address, op_type and i_val latched there.
REQ-022 Load hit (valid & tag match): stay IDLE; resp_valid = 1 and o_val = line data on the next cycle (latency 1); back-to-back hits at one per cycle.
REQ-023 Load miss: IDLE -> MEM_REQ with mem_we=0, mem_addr = latched address with [1:0]=0.
REQ-024 Store (hit or miss): write-through; IDLE -> MEM_REQ with mem_we=1, mem_wdata = i_val; on a hit the line data is updated at acceptance; a miss does not allocate.
REQ-025 MEM_REQ: mem_req_valid held high with stable mem_addr/mem_we/mem_wdata until mem_req_ready; on handshake -> MEM_WAIT, mem_req_valid low.
REQ-026 MEM_WAIT: on mem_resp_valid -> IDLE; next cycle resp_valid = 1; for a load, line filled (valid=1, tag, mem_rdata) and o_val = mem_rdata.
REQ-027 mem_resp_valid outside MEM_WAIT is ignored.
REQ-028 flush sampled in IDLE clears all valid bits in one cycle and takes priority over a same-cycle req_valid (not accepted); flush outside IDLE is ignored.
REQ-029 hit_cnt / miss_cnt increment by 1 per accepted load hit / miss, wrapping 0xFFFFFFFF -> 0; stores do not count.
REQ-030 o_val holds its last value between responses; resp_valid is never high for two consecutive cycles for the same request.

Reset
REQ-031 On rst low, immediately: state IDLE, all valid bits 0, req_ready 1 after release, resp_valid 0, o_val 0, mem_req_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, hit_cnt 0, miss_cnt 0.
REQ-032 Reset mid-operation abandons the transaction; no response is issued and later mem_resp_valid is ignored.
REQ-033 Line data and tags need not be reset.

Verification
REQ-034 Load 0x100 after reset, memory returns 0xDEADBEEF after 3 cycles -> mem read 0x100 issued, resp_valid with o_val 0xDEADBEEF, miss_cnt 1; repeat load -> response next cycle, hit_cnt 1, no memory request.
REQ-035 Store 0x12345678 to cached 0x100 -> mem write 0x100/0x12345678, resp_valid after mem_resp_valid; load 0x100 hits returning 0x12345678.
REQ-036 Load 0x100 then 0x140 (same index, LINES=16) -> both miss, second evicts first; load 0x100 misses again, miss_cnt 3.
REQ-037 Flush with req_valid in same cycle -> req_ready 0, request accepted next cycle; previously cached 0x140 now misses.
REQ-038 mem_req_ready held low 5 cycles -> mem_req_valid/mem_addr stable throughout; rst pulse during MEM_WAIT -> mem_req_valid 0, no resp_valid, counters 0.
